// File: rtl/axi_single_beat_to_mem_if.sv
// axi_single_beat_to_mem_if
//   Bundles the AXI4 single-beat channels (AW, W, B, AR, R) and the
//   req/gnt/rvalid memory port of axi_single_beat_to_mem.
//   Signal names keep the _i/_o suffixes of the converter's side, so
//   "slave" is the converter's view and "master" is the environment's
//   view (AXI master plus memory).
//
//   Optional build macro: AXI_SB_MEM_ERR_EN adds mem_err_i.
//
//   Parameters: AddrWidth, DataWidth, IdWidth (StrbWidth = DataWidth/8).
interface axi_single_beat_to_mem_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 4
);
  localparam int unsigned StrbWidth = DataWidth / 8;

  // write address
  logic [IdWidth-1:0]   aw_id_i;
  logic [AddrWidth-1:0] aw_addr_i;
  logic                 aw_valid_i;
  logic                 aw_ready_o;
  // write data
  logic [DataWidth-1:0] w_data_i;
  logic [StrbWidth-1:0] w_strb_i;
  logic                 w_valid_i;
  logic                 w_ready_o;
  // write response
  logic [IdWidth-1:0]   b_id_o;
  logic [1:0]           b_resp_o;
  logic                 b_valid_o;
  logic                 b_ready_i;
  // read address
  logic [IdWidth-1:0]   ar_id_i;
  logic [AddrWidth-1:0] ar_addr_i;
  logic                 ar_valid_i;
  logic                 ar_ready_o;
  // read data
  logic [IdWidth-1:0]   r_id_o;
  logic [DataWidth-1:0] r_data_o;
  logic [1:0]           r_resp_o;
  logic                 r_last_o;
  logic                 r_valid_o;
  logic                 r_ready_i;
  // memory port
  logic                 mem_req_o;
  logic                 mem_gnt_i;
  logic [AddrWidth-1:0] mem_addr_o;
  logic                 mem_we_o;
  logic [DataWidth-1:0] mem_wdata_o;
  logic [StrbWidth-1:0] mem_be_o;
  logic                 mem_rvalid_i;
  logic [DataWidth-1:0] mem_rdata_i;
`ifdef AXI_SB_MEM_ERR_EN
  logic                 mem_err_i;
`endif

  modport slave (
`ifdef AXI_SB_MEM_ERR_EN
    input  mem_err_i,
`endif
    input  aw_id_i, aw_addr_i, aw_valid_i,
    output aw_ready_o,
    input  w_data_i, w_strb_i, w_valid_i,
    output w_ready_o,
    output b_id_o, b_resp_o, b_valid_o,
    input  b_ready_i,
    input  ar_id_i, ar_addr_i, ar_valid_i,
    output ar_ready_o,
    output r_id_o, r_data_o, r_resp_o, r_last_o, r_valid_o,
    input  r_ready_i,
    output mem_req_o,
    input  mem_gnt_i,
    output mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o,
    input  mem_rvalid_i, mem_rdata_i
  );

  modport master (
`ifdef AXI_SB_MEM_ERR_EN
    output mem_err_i,
`endif
    output aw_id_i, aw_addr_i, aw_valid_i,
    input  aw_ready_o,
    output w_data_i, w_strb_i, w_valid_i,
    input  w_ready_o,
    input  b_id_o, b_resp_o, b_valid_o,
    output b_ready_i,
    output ar_id_i, ar_addr_i, ar_valid_i,
    input  ar_ready_o,
    input  r_id_o, r_data_o, r_resp_o, r_last_o, r_valid_o,
    output r_ready_i,
    input  mem_req_o,
    output mem_gnt_i,
    input  mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o,
    output mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/axi_single_beat_to_mem.sv
// axi_single_beat_to_mem
//   Turns single-beat AXI4 transactions (len=0, FIXED) into a req/gnt/rvalid
//   memory access. One transaction is in flight at a time; the B or R
//   response carries the originating ID. Write and read channels are
//   arbitrated with a flip-flopping priority bit (read first after reset).
//
//   Ports:
//     clk_i   rising-edge clock
//     rst_ni  asynchronous active-low reset
//     bus     axi_single_beat_to_mem_if.slave: AW/W/B/AR/R channels and
//             the memory port (mem_req/gnt, payload, rvalid/rdata)
//
//   Optional build macro: AXI_SB_MEM_ERR_EN
//     defined   -> mem_err_i is sampled with mem_rvalid_i; an error returns
//                  SLVERR (2'b10) on B/R, read data still forwarded.
//     undefined -> no mem_err_i, responses always OKAY.
//
//   Sequence per transaction: IDLE (accept) -> REQ (until gnt) ->
//   WAIT (until rvalid) -> RESP (until b/r ready) -> IDLE.
module axi_single_beat_to_mem #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  axi_single_beat_to_mem_if.slave  bus
);
  localparam int unsigned StrbWidth = DataWidth / 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic PRIO_READ  = 1'b0;
  localparam logic PRIO_WRITE = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [1:0]           state_q;
  logic                 prio_q;

  // request payload, written only on the IDLE accept
  logic                 we_q;
  logic [IdWidth-1:0]   id_q;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] wdata_q;
  logic [StrbWidth-1:0] be_q;

  // response data captured in WAIT
  logic [DataWidth-1:0] rdata_q;
  logic [1:0]           resp;

  logic wr_elig;
  logic rd_elig;
  logic take_wr;
  logic take_rd;
  logic resp_done;

  // Arbitration. A write needs AW and W together so AW is never taken alone.
  // The ready outputs come straight from this decode; gating with rst_ni keeps
  // them low while reset is held even if the masters already assert valid.
  always_comb begin
    wr_elig = bus.aw_valid_i & bus.w_valid_i;
    rd_elig = bus.ar_valid_i;
    take_wr = 1'b0;
    take_rd = 1'b0;
    if (rst_ni && (state_q == IDLE)) begin
      if (wr_elig && rd_elig) begin
        take_rd = (prio_q == PRIO_READ);
        take_wr = (prio_q == PRIO_WRITE);
      end else begin
        take_rd = rd_elig;
        take_wr = wr_elig;
      end
    end
  end

  assign resp_done = (state_q == RESP) &&
                     ((we_q && bus.b_ready_i) || (!we_q && bus.r_ready_i));

  // State and arbitration priority
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      prio_q  <= PRIO_READ;
    end else begin
      case (state_q)
        IDLE: begin
          if (take_wr) begin
            state_q <= REQ;
            prio_q  <= PRIO_READ;
          end else if (take_rd) begin
            state_q <= REQ;
            prio_q  <= PRIO_WRITE;
          end
        end
        REQ: begin
          if (bus.mem_gnt_i) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_rvalid_i) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          if (resp_done) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Request payload. Reads drive all byte enables; wdata keeps its old value
  // on a read since the memory ignores it when we=0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (take_wr) begin
      we_q    <= 1'b1;
      id_q    <= bus.aw_id_i;
      addr_q  <= bus.aw_addr_i;
      wdata_q <= bus.w_data_i;
      be_q    <= bus.w_strb_i;
    end else if (take_rd) begin
      we_q    <= 1'b0;
      id_q    <= bus.ar_id_i;
      addr_q  <= bus.ar_addr_i;
      be_q    <= '1;
    end
  end

  // Memory response capture; rvalid outside WAIT is not ours and is dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if ((state_q == WAIT) && bus.mem_rvalid_i) begin
      rdata_q <= bus.mem_rdata_i;
    end
  end

`ifdef AXI_SB_MEM_ERR_EN
  logic err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if ((state_q == WAIT) && bus.mem_rvalid_i) begin
      err_q <= bus.mem_err_i;
    end
  end

  assign resp = err_q ? RESP_SLVERR : RESP_OKAY;
`else
  assign resp = RESP_OKAY;
`endif

  // AXI handshakes
  assign bus.aw_ready_o = take_wr;
  assign bus.w_ready_o  = take_wr;
  assign bus.ar_ready_o = take_rd;

  // Responses depend on registered state only, never on b/r ready.
  assign bus.b_valid_o  = (state_q == RESP) && we_q;
  assign bus.b_id_o     = id_q;
  assign bus.b_resp_o   = resp;

  assign bus.r_valid_o  = (state_q == RESP) && !we_q;
  assign bus.r_id_o     = id_q;
  assign bus.r_data_o   = rdata_q;
  assign bus.r_resp_o   = resp;
  assign bus.r_last_o   = 1'b1;

  // Memory port
  assign bus.mem_req_o   = (state_q == REQ);
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_we_o    = we_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.mem_be_o    = be_q;

endmodule

// File: tb/tb_axi_single_beat_to_mem.sv
module tb_axi_single_beat_to_mem;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 4;
  localparam int unsigned SW = DW / 8;

`ifdef AXI_SB_MEM_ERR_EN
  localparam logic [1:0] ERR_RESP = 2'b10;
`else
  localparam logic [1:0] ERR_RESP = 2'b00;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  axi_single_beat_to_mem_if #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)) bus ();

  axi_single_beat_to_mem #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit             is_wr;
    logic [IW-1:0]  id;
    logic [DW-1:0]  data;
    logic [1:0]     resp;
    int             lat;
  } rsp_t;

  typedef struct {
    bit             we;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic [SW-1:0]  be;
    logic [DW-1:0]  rdata;
    bit             err;
    int             gnt_dly;
    int             rv_dly;
  } mreq_t;

  rsp_t        rspq[$];
  mreq_t       memq[$];
  int unsigned accq[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic void fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endfunction

  function automatic void exp_w(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                                input logic [DW-1:0] data, input logic [SW-1:0] strb,
                                input bit err, input int gnt_dly, input int lat);
    mreq_t m;
    rsp_t  r;
    m.we = 1'b1; m.addr = addr; m.wdata = data; m.be = strb; m.rdata = '0;
    m.err = err; m.gnt_dly = gnt_dly; m.rv_dly = 1;
    memq.push_back(m);
    r.is_wr = 1'b1; r.id = id; r.data = '0; r.resp = err ? ERR_RESP : 2'b00; r.lat = lat;
    rspq.push_back(r);
  endfunction

  function automatic void exp_r(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                                input logic [DW-1:0] rdata, input bit err, input int gnt_dly,
                                input int rv_dly, input int lat, input bit want_rsp);
    mreq_t m;
    rsp_t  r;
    m.we = 1'b0; m.addr = addr; m.wdata = '0; m.be = '1; m.rdata = rdata;
    m.err = err; m.gnt_dly = gnt_dly; m.rv_dly = rv_dly;
    memq.push_back(m);
    if (want_rsp) begin
      r.is_wr = 1'b0; r.id = id; r.data = rdata; r.resp = err ? ERR_RESP : 2'b00; r.lat = lat;
      rspq.push_back(r);
    end
  endfunction

  // Memory model: grants after gnt_dly extra cycles, returns rvalid rv_dly cycles after grant.
  initial begin : mem_model
    mreq_t cur;
    int unsigned req_cnt;
    int rv_cnt;
    bit have;
    req_cnt = 0; rv_cnt = 0; have = 1'b0;
    cur = '{default: '0};
    bus.mem_gnt_i = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i = '0;
`ifdef AXI_SB_MEM_ERR_EN
    bus.mem_err_i = 1'b0;
`endif
    forever begin
      @(negedge clk);
      bus.mem_gnt_i = 1'b0;
      bus.mem_rvalid_i = 1'b0;
      if (!rst_n) begin
        have = 1'b0;
        req_cnt = 0;
      end
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i = cur.rdata;
`ifdef AXI_SB_MEM_ERR_EN
          bus.mem_err_i = cur.err;
`endif
        end
      end else if (rst_n && bus.mem_req_o) begin
        if (!have) begin
          if (memq.size() == 0) begin
            fail("mem_req_unexpected");
            cur = '{default: '0};
            cur.rv_dly = 1;
          end else begin
            cur = memq.pop_front();
          end
          have = 1'b1;
          req_cnt = 0;
        end
        chk("mem_we", bus.mem_we_o, cur.we);
        chk("mem_addr", bus.mem_addr_o, cur.addr);
        chk("mem_be", bus.mem_be_o, cur.be);
        if (cur.we) chk("mem_wdata", bus.mem_wdata_o, cur.wdata);
        if (req_cnt == cur.gnt_dly) begin
          bus.mem_gnt_i = 1'b1;
          rv_cnt = cur.rv_dly;
          have = 1'b0;
          req_cnt = 0;
        end else begin
          req_cnt++;
        end
      end else if (have) begin
        fail("mem_req_dropped");
        have = 1'b0;
      end
    end
  end

  // Monitor: accept times, response scoreboard, hold and ready-pair checks.
  initial begin : monitor
    rsp_t e;
    bit r_stall, b_stall, is_wr;
    logic [DW-1:0] pr_data;
    logic [IW-1:0] pr_id, pb_id;
    int unsigned acc;
    r_stall = 1'b0; b_stall = 1'b0;
    pr_data = '0; pr_id = '0; pb_id = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        r_stall = 1'b0;
        b_stall = 1'b0;
        continue;
      end
      if (bus.aw_ready_o || bus.w_ready_o)
        chk("aw_w_ready_pair", bus.aw_ready_o, bus.w_ready_o);
      if (bus.b_valid_o || bus.r_valid_o)
        chk("ready_while_resp", {bus.aw_ready_o, bus.ar_ready_o}, 2'b00);
      if (r_stall) begin
        chk("r_hold_valid", bus.r_valid_o, 1'b1);
        chk("r_hold_data", bus.r_data_o, pr_data);
        chk("r_hold_id", bus.r_id_o, pr_id);
      end
      if (b_stall) begin
        chk("b_hold_valid", bus.b_valid_o, 1'b1);
        chk("b_hold_id", bus.b_id_o, pb_id);
      end
      if ((bus.aw_valid_i && bus.aw_ready_o) || (bus.ar_valid_i && bus.ar_ready_o))
        accq.push_back(cyc);
      for (int k = 0; k < 2; k++) begin
        is_wr = (k == 0);
        if (is_wr ? (bus.b_valid_o && bus.b_ready_i) : (bus.r_valid_o && bus.r_ready_i)) begin
          if (rspq.size() == 0) begin
            fail(is_wr ? "b_unexpected" : "r_unexpected");
          end else begin
            e = rspq.pop_front();
            chk("rsp_kind_is_write", is_wr, e.is_wr);
            if (is_wr) begin
              chk("b_id", bus.b_id_o, e.id);
              chk("b_resp", bus.b_resp_o, e.resp);
            end else begin
              chk("r_id", bus.r_id_o, e.id);
              chk("r_data", bus.r_data_o, e.data);
              chk("r_resp", bus.r_resp_o, e.resp);
              chk("r_last", bus.r_last_o, 1'b1);
            end
            if (accq.size() == 0) begin
              fail("accept_missing");
            end else begin
              acc = accq.pop_front();
              if (e.lat >= 0) chk("latency", cyc - acc, e.lat);
            end
          end
        end
      end
      r_stall = bus.r_valid_o && !bus.r_ready_i;
      b_stall = bus.b_valid_o && !bus.b_ready_i;
      pr_data = bus.r_data_o;
      pr_id   = bus.r_id_o;
      pb_id   = bus.b_id_o;
    end
  end

  task automatic drive_w(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [SW-1:0] strb);
    int unsigned n = 0;
    @(negedge clk);
    bus.aw_id_i = id; bus.aw_addr_i = addr; bus.w_data_i = data; bus.w_strb_i = strb;
    bus.aw_valid_i = 1'b1; bus.w_valid_i = 1'b1;
    #1;
    while (!bus.aw_ready_o) begin
      @(negedge clk); #1; n++;
      if (n > 300) begin fail("aw_accept_timeout"); break; end
    end
    @(posedge clk); #1;
    bus.aw_valid_i = 1'b0; bus.w_valid_i = 1'b0;
  endtask

  task automatic drive_r(input logic [IW-1:0] id, input logic [AW-1:0] addr);
    int unsigned n = 0;
    @(negedge clk);
    bus.ar_id_i = id; bus.ar_addr_i = addr; bus.ar_valid_i = 1'b1;
    #1;
    while (!bus.ar_ready_o) begin
      @(negedge clk); #1; n++;
      if (n > 300) begin fail("ar_accept_timeout"); break; end
    end
    @(posedge clk); #1;
    bus.ar_valid_i = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((rspq.size() != 0 || memq.size() != 0) && n < 500) begin
      @(negedge clk); n++;
    end
    if (n >= 500) begin
      fail("drain_timeout");
      rspq.delete(); memq.delete(); accq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_sig(input string name, input int sel);
    int unsigned n = 0;
    logic s;
    s = 1'b0;
    while (!s && n < 300) begin
      @(negedge clk); #1; n++;
      case (sel)
        0: s = bus.b_valid_o;
        1: s = bus.r_valid_o;
        default: s = bus.mem_gnt_i;
      endcase
    end
    if (!s) fail(name);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin : stim
    bus.aw_id_i = '0; bus.aw_addr_i = '0; bus.aw_valid_i = 1'b0;
    bus.w_data_i = '0; bus.w_strb_i = '0; bus.w_valid_i = 1'b0;
    bus.ar_id_i = '0; bus.ar_addr_i = '0; bus.ar_valid_i = 1'b0;
    bus.b_ready_i = 1'b1; bus.r_ready_i = 1'b1;

    // reset state, with all request valids high to see readies held low
    repeat (2) @(negedge clk);
    bus.aw_valid_i = 1'b1; bus.w_valid_i = 1'b1; bus.ar_valid_i = 1'b1;
    #2;
    chk("rst_aw_ready", bus.aw_ready_o, 1'b0);
    chk("rst_w_ready", bus.w_ready_o, 1'b0);
    chk("rst_ar_ready", bus.ar_ready_o, 1'b0);
    chk("rst_b_valid", bus.b_valid_o, 1'b0);
    chk("rst_r_valid", bus.r_valid_o, 1'b0);
    chk("rst_mem_req", bus.mem_req_o, 1'b0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
    chk("rst_mem_we", bus.mem_we_o, 1'b0);
    chk("rst_mem_be", bus.mem_be_o, 4'h0);
    chk("rst_mem_wdata", bus.mem_wdata_o, 32'h0);
    bus.aw_valid_i = 1'b0; bus.w_valid_i = 1'b0; bus.ar_valid_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single write, minimum latency
    exp_w(4'd3, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 0, 3);
    drive_w(4'd3, 32'h100, 32'hDEADBEEF, 4'hF);
    drain();

    // single read
    exp_r(4'd5, 32'h40, 32'h12345678, 1'b0, 0, 1, 3, 1'b1);
    drive_r(4'd5, 32'h40);
    drain();

    // contention from reset: R, B, R, B
    pulse_reset();
    exp_r(4'd1, 32'h10, 32'hA1A1A1A1, 1'b0, 0, 1, 3, 1'b1);
    exp_w(4'd2, 32'h20, 32'hB2B2B2B2, 4'h3, 1'b0, 0, 3);
    exp_r(4'd3, 32'h30, 32'hC3C3C3C3, 1'b0, 0, 1, 3, 1'b1);
    exp_w(4'd4, 32'h40, 32'hD4D4D4D4, 4'hC, 1'b0, 0, 3);
    fork
      begin
        drive_w(4'd2, 32'h20, 32'hB2B2B2B2, 4'h3);
        drive_w(4'd4, 32'h40, 32'hD4D4D4D4, 4'hC);
      end
      begin
        drive_r(4'd1, 32'h10);
        drive_r(4'd3, 32'h30);
      end
    join
    drain();

    // grant delayed 5 cycles: req held 6 cycles with stable payload
    exp_w(4'd6, 32'h200, 32'h55AA55AA, 4'h5, 1'b0, 5, 8);
    drive_w(4'd6, 32'h200, 32'h55AA55AA, 4'h5);
    drain();

    // b_ready low for 2 cycles
    bus.b_ready_i = 1'b0;
    exp_w(4'd7, 32'h204, 32'h00000001, 4'hF, 1'b0, 0, 5);
    drive_w(4'd7, 32'h204, 32'h00000001, 4'hF);
    wait_sig("b_valid_timeout", 0);
    repeat (2) @(negedge clk);
    bus.b_ready_i = 1'b1;
    drain();

    // r_ready low for 3 cycles, a pending write must not be accepted
    bus.r_ready_i = 1'b0;
    exp_r(4'd8, 32'h208, 32'h87654321, 1'b0, 0, 1, 6, 1'b1);
    drive_r(4'd8, 32'h208);
    wait_sig("r_valid_timeout", 1);
    bus.aw_id_i = 4'd9; bus.aw_addr_i = 32'h20C; bus.w_data_i = 32'h0; bus.w_strb_i = 4'h1;
    bus.aw_valid_i = 1'b1; bus.w_valid_i = 1'b1;
    repeat (2) @(negedge clk);
    bus.aw_valid_i = 1'b0; bus.w_valid_i = 1'b0;
    @(negedge clk);
    bus.r_ready_i = 1'b1;
    drain();

    // memory error on read and write
    exp_r(4'd9, 32'h80, 32'hCAFEF00D, 1'b1, 0, 1, 3, 1'b1);
    drive_r(4'd9, 32'h80);
    drain();
    exp_w(4'd10, 32'h84, 32'h13572468, 4'hF, 1'b1, 0, 3);
    drive_w(4'd10, 32'h84, 32'h13572468, 4'hF);
    drain();

    // reset while in WAIT, late rvalid must be ignored
    exp_r(4'd2, 32'h300, 32'h77777777, 1'b0, 0, 4, -1, 1'b0);
    drive_r(4'd2, 32'h300);
    wait_sig("gnt_timeout", 2);
    @(negedge clk); rst_n = 1'b0;
    #2;
    chk("rstw_mem_req", bus.mem_req_o, 1'b0);
    chk("rstw_r_valid", bus.r_valid_o, 1'b0);
    chk("rstw_mem_addr", bus.mem_addr_o, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("post_rst_r_valid", bus.r_valid_o, 1'b0);
    chk("post_rst_b_valid", bus.b_valid_o, 1'b0);
    accq.delete();
    exp_r(4'd7, 32'h44, 32'h0BADCAFE, 1'b0, 0, 1, 3, 1'b1);
    drive_r(4'd7, 32'h44);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
